// File: rtl/audio_manip.sv
// audio_manip: stereo record/playback buffer between codec receive and transmit.
// Live input is passed through while idle or recording. A recording captures
// NUM_SAMPLES consecutive L/R pairs, and a playback replays them one per sample slot.
module audio_manip #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start_write,
    input  logic              start_read,
    input  logic              new_sample,
    input  logic [DATA_W-1:0] in_l,
    input  logic [DATA_W-1:0] in_r,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              writeComplete,
    output logic              readReady
);

    localparam int NUM_SAMPLES = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY
    } state_t;

    state_t state;
    state_t next_state;

    logic                ns_d;
    logic                strobe;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_last;
    logic                rd_last;
    logic [2*DATA_W-1:0] rd_word;
    logic [2*DATA_W-1:0] mem [0:NUM_SAMPLES-1];

    // Each rising edge of the codec toggle marks one sample slot.
    assign strobe  = new_sample & ~ns_d;
    assign wr_last = &wr_addr;
    assign rd_last = &rd_addr;
    assign rd_word = mem[rd_addr];

    // Delay new_sample by one clock so that its rising edge can be detected.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            ns_d <= 1'b0;
        end else begin
            ns_d <= new_sample;
        end
    end

    // State register. A reset aborts any recording or playback in progress.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Requests are accepted only in IDLE, and start_write wins over start_read.
    // A recording or playback ends on the strobe that handles the last address.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_write) begin
                    next_state = RECORD;
                end else if (start_read && writeComplete) begin
                    next_state = PLAY;
                end
            end
            RECORD: begin
                if (strobe && wr_last) begin
                    next_state = IDLE;
                end
            end
            PLAY: begin
                if (strobe && rd_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath. Handles passthrough, address counters, the sticky writeComplete flag and the readReady pulse.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            out_l         <= '0;
            out_r         <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            writeComplete <= 1'b0;
            readReady     <= 1'b0;
        end else begin
            readReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        out_l <= in_l;
                        out_r <= in_r;
                    end
                    if (start_write) begin
                        wr_addr       <= '0;
                        writeComplete <= 1'b0;
                    end else if (start_read && writeComplete) begin
                        rd_addr <= '0;
                    end
                end
                RECORD: begin
                    if (strobe) begin
                        out_l   <= in_l;
                        out_r   <= in_r;
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_last) begin
                            writeComplete <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (strobe) begin
                        out_l     <= rd_word[2*DATA_W-1:DATA_W];
                        out_r     <= rd_word[DATA_W-1:0];
                        readReady <= 1'b1;
                        rd_addr   <= rd_addr + 1'b1;
                    end
                end
                default: begin
                    readReady <= 1'b0;
                end
            endcase
        end
    end

    // Sample RAM. Reset leaves it untouched, and only strobes taken during RECORD write to it.
    always_ff @(posedge clk) begin
        if (state == RECORD && strobe) begin
            mem[wr_addr] <= {in_l, in_r};
        end
    end

endmodule

// File: tb/tb_audio_manip.sv
// tb_audio_manip: directed bench for audio_manip.
// Expected playback samples are queued when playback is requested.
// A monitor pops one expected sample for each readReady pulse it sees.
module tb_audio_manip;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int NUM    = 16;

    logic              clk;
    logic              RESET;
    logic              start_write;
    logic              start_read;
    logic              new_sample;
    logic [DATA_W-1:0] in_l;
    logic [DATA_W-1:0] in_r;
    logic [DATA_W-1:0] out_l;
    logic [DATA_W-1:0] out_r;
    logic              writeComplete;
    logic              readReady;

    logic [2*DATA_W-1:0] sb[$];
    int vectors;
    int miscompares;

    audio_manip #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .start_write  (start_write),
        .start_read   (start_read),
        .new_sample   (new_sample),
        .in_l         (in_l),
        .in_r         (in_r),
        .out_l        (out_l),
        .out_r        (out_r),
        .writeComplete(writeComplete),
        .readReady    (readReady)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [2*DATA_W-1:0] obs,
                               input logic [2*DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one sample pair together with one rising edge of new_sample.
    // The task returns at a falling edge after the strobe edge has been taken.
    task automatic applyStimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        @(negedge clk);
        in_l       = l;
        in_r       = r;
        new_sample = 1'b1;
        @(negedge clk);
        new_sample = 1'b0;
        @(negedge clk);
    endtask

    // Replay the recording of k/~k and check each sample through the scoreboard.
    // start_write is optionally held high for the first few playback strobes.
    task automatic runPlayback(input string tag, input int hold_write);
        logic [DATA_W-1:0] kv;
        for (int k = 0; k < NUM; k++) begin
            kv = DATA_W'(k);
            sb.push_back({kv, ~kv});
        end
        @(negedge clk);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        if (hold_write > 0) start_write = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            if (k == hold_write) start_write = 1'b0;
            applyStimulus(24'hA5A5A5, 24'h5A5A5A);
        end
        start_write = 1'b0;
        checkOutput({tag, "_all_played"}, 48'(sb.size()), 48'd0);
        checkOutput({tag, "_hold_last"}, {out_l, out_r}, {24'd15, ~24'd15});
    endtask

    // Scoreboard monitor. Every readReady pulse must match the oldest queued sample.
    always @(negedge clk) begin
        if (readReady === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpected_readReady: observed pulse with out %h/%h expected none",
                       out_l, out_r);
            end else begin
                checkOutput("playback_sample", {out_l, out_r}, sb.pop_front());
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b0;
        start_write = 1'b0;
        start_read  = 1'b0;
        new_sample  = 1'b0;
        in_l        = '0;
        in_r        = '0;

        // Reset held with strobes running.
        applyStimulus(24'h111111, 24'h222222);
        applyStimulus(24'h333333, 24'h444444);
        checkOutput("reset_out", {out_l, out_r}, 48'd0);
        checkOutput("reset_wc", 48'(writeComplete), 48'd0);
        checkOutput("reset_rr", 48'(readReady), 48'd0);
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_out", {out_l, out_r}, 48'd0);

        // Passthrough in IDLE.
        applyStimulus(24'h123456, 24'hABCDEF);
        checkOutput("passthrough", {out_l, out_r}, {24'h123456, 24'hABCDEF});

        // start_read with no recording is ignored, so passthrough continues.
        start_read = 1'b1;
        applyStimulus(24'h0F0F0F, 24'hF0F0F0);
        applyStimulus(24'h00BEEF, 24'hFACE00);
        start_read = 1'b0;
        checkOutput("guard_read_idle", {out_l, out_r}, {24'h00BEEF, 24'hFACE00});
        checkOutput("guard_read_wc", 48'(writeComplete), 48'd0);

        // Record 16 samples of k/~k.
        @(negedge clk);
        start_write = 1'b1;
        @(negedge clk);
        start_write = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            logic [DATA_W-1:0] kv;
            kv = DATA_W'(k);
            applyStimulus(kv, ~kv);
            if (k == 0) checkOutput("record_passthrough", {out_l, out_r}, {kv, ~kv});
            if (k == NUM - 2) checkOutput("record_wc_before_end", 48'(writeComplete), 48'd0);
        end
        checkOutput("record_wc_done", 48'(writeComplete), 48'd1);

        // Playback, then back to IDLE passthrough.
        runPlayback("play1", 0);
        applyStimulus(24'h000777, 24'h000888);
        checkOutput("idle_after_play", {out_l, out_r}, {24'h000777, 24'h000888});

        // start_write during PLAY is ignored and the recording survives.
        runPlayback("play2", 4);
        checkOutput("play2_wc", 48'(writeComplete), 48'd1);
        runPlayback("play3", 0);

        // Abort a recording with reset after 5 strobes.
        @(negedge clk);
        start_write = 1'b1;
        @(negedge clk);
        start_write = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(24'h100000 + DATA_W'(k), 24'h200000);
        RESET = 1'b0;
        @(negedge clk);
        checkOutput("abort_wc", 48'(writeComplete), 48'd0);
        checkOutput("abort_out", {out_l, out_r}, 48'd0);
        RESET = 1'b1;
        @(negedge clk);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        applyStimulus(24'h0000AB, 24'h0000CD);
        applyStimulus(24'h0000EF, 24'h000012);
        checkOutput("abort_read_ignored", {out_l, out_r}, {24'h0000EF, 24'h000012});
        checkOutput("final_queue_empty", 48'(sb.size()), 48'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
